ysyx_23060180_lsu: RTL and testbench
====================================

Name: ysyx_23060180_lsu

Overview:
- Parametrised load/store unit that takes memory operations off the core's fixed one-cycle memory path.
- Core side: a valid/ready request channel (address, data, func3, rd) and a valid/ready response channel (aligned, extended load data or an error code).
- Memory side: holds a word-aligned command until the bus acks, so the bus may have variable latency, with a timeout.
- Adds XLEN 32/64 support, byte-lane steering, and misaligned/illegal/timeout error reporting.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum bus cycles without ack before a timeout error; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  LSU can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_func3  in  3  RISC-V load/store func3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- req_rd  in  5  load destination register
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_rd  out  5  rd for loads; 0 for stores
- resp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal func3
- mem_rd  out  1  read command
- mem_wr  out  1  write command
- mem_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared
- mem_wdata  out  XLEN  store data shifted to its byte lane
- mem_wstrb  out  XLEN/8  byte write strobes
- mem_rdata  in  XLEN  read data, valid when mem_ack is high
- mem_ack  in  1  command completion, for reads and writes

Behaviour:
- Async reset:
  - state IDLE, counter 0, all captured request fields 0.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, resp_rd=0, mem_rd=0, mem_wr=0, mem_wstrb=0.
  - Reset mid-operation drops mem_rd/mem_wr immediately, since they decode combinationally from state.
- States:
  - IDLE: req_ready=1. When req_valid is high, capture the request.
    - Illegal func3 -> RESP with err=3.
    - Misaligned address -> RESP with err=1.
    - Otherwise -> BUS, counter cleared.
  - BUS: mem_rd=!wr or mem_wr=wr; mem_addr, mem_wdata and mem_wstrb held constant.
    - mem_ack -> RESP with err=0, load data captured this cycle.
    - Else if TIMEOUT!=0 and the counter equals TIMEOUT-1 -> RESP with err=2.
    - Else increment the counter.
    - An ack on the last allowed cycle counts as success.
  - RESP: resp_valid=1, all resp_* held stable. resp_ready -> IDLE.
- mem_ack in IDLE or RESP is ignored.
- Latency:
  - Accept at edge N; bus command visible in cycle N+1.
  - Ack in N+1 gives resp_valid in N+2.
  - Error responses without a bus access give resp_valid in N+1.
  - Minimum one op per 3 cycles; the LSU never accepts a new request while holding a response.
- func3 legality:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011 ld and 110 lwu legal only when XLEN=64; 111 illegal.
  - Stores: 000 sb, 001 sh, 010 sw; 011 sd legal only when XLEN=64; 1xx illegal.
- Alignment: byte any address; half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- Lane steering:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_wdata = req_wdata << (8*off).
  - mem_wstrb = size mask (1, 3, 0xF, 0xFF) << off.
  - mem_wstrb = 0 for reads.
- Load data:
  - Shift mem_rdata right by 8*off, then extend.
  - lb/lh/lw (and ld) sign-extend to XLEN; lbu/lhu/lwu zero-extend.
- resp_rd and resp_rdata are 0 whenever resp_err != 0.

Test Plan:
- XLEN=32, lb, addr 0x80000003, mem_rdata 0x80FF1234, ack in first BUS cycle:
  - mem_addr=0x80000000, mem_rd=1 for 1 cycle.
  - resp_rdata=0xFFFFFF80, err=0, resp_valid 2 cycles after accept.
- XLEN=32, sh, addr 0x80000002, wdata 0x0000ABCD, ack after 5 BUS cycles:
  - mem_wstrb=0xC, mem_wdata=0xABCD0000 held 5 cycles.
  - resp err=0, resp_rd=0.
- lw to 0x80000001:
  - no mem_rd pulse; resp_valid next cycle with err=1, rdata=0.
- TIMEOUT=4, lw with ack never asserted:
  - mem_rd high exactly 4 cycles, then resp err=2.
  - Repeat with ack on the 4th cycle -> err=0.
- Hold resp_ready=0 for 3 cycles after a load response:
  - resp_* stable, req_ready=0 throughout.
  - resp_ready=1 -> next cycle IDLE, req_ready=1.
- XLEN=32, func3=011 load -> err=3, no bus access.
- XLEN=64, ld at 0x8: mem_wstrb=0, resp_rdata = full mem_rdata.
- Reset asserted during BUS: mem_rd falls immediately; a later ack yields no response.

Source files
------------

// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: moves core memory ops onto a variable-latency bus and steers byte lanes.
// Latency: accept at edge N, bus command in N+1, response one cycle after ack; early errors respond in N+1.
// Backpressure: req_ready only in IDLE; a response is held stable until resp_ready, blocking new requests.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake: req_wr, req_func3, req_addr, req_wdata, req_rd
//   resp_valid/resp_ready          response handshake: resp_rdata, resp_rd, resp_err (0 ok, 1 misaligned, 2 timeout, 3 illegal)
//   mem_rd/mem_wr                  bus command, held until mem_ack: mem_addr, mem_wdata, mem_wstrb, mem_rdata
module ysyx_23060180_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [2:0]          req_func3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [4:0]          resp_rd,
    output logic [1:0]          resp_err,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    // Counter value on the last bus cycle allowed before a timeout.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t              state;
    logic                wr_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [4:0]          rd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     rdata_q;
    logic [4:0]          resp_rd_q;
    logic [1:0]          err_q;

    logic                illegal;
    logic                misaligned;
    logic [OFF_W-1:0]    off;
    logic [NB-1:0]       size_mask;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     ld_ext;

    // Request classification, evaluated on the incoming request in IDLE.
    always_comb begin
        illegal = 1'b0;
        if (req_wr) begin
            illegal = req_func3[2] || ((req_func3[1:0] == 2'b11) && (XLEN == 32));
        end else begin
            illegal = (req_func3 == 3'b111) ||
                      ((XLEN == 32) && ((req_func3 == 3'b011) || (req_func3 == 3'b110)));
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (req_func3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // Lane steering from the captured request; stable for the whole bus phase.
    assign off = addr_q[OFF_W-1:0];

    always_comb begin
        size_mask = '0;
        case (f3_q[1:0])
            2'b00:   size_mask = NB'(8'h01);
            2'b01:   size_mask = NB'(8'h03);
            2'b10:   size_mask = NB'(8'h0F);
            default: size_mask = NB'(8'hFF);
        endcase
    end

    // Load data: bring the addressed lane to bit 0, then extend by size/signedness.
    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (f3_q[1:0])
            2'b00:   ld_ext = f3_q[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'b01:   ld_ext = f3_q[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'b10:   ld_ext = f3_q[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            wr_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_rd_q <= '0;
            err_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_wr;
                        f3_q      <= req_func3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rd_q      <= req_rd;
                        cnt_q     <= '0;
                        rdata_q   <= '0;
                        resp_rd_q <= '0;
                        if (illegal) begin
                            err_q <= 2'd3;
                            state <= S_RESP;
                        end else if (misaligned) begin
                            err_q <= 2'd1;
                            state <= S_RESP;
                        end else begin
                            err_q <= 2'd0;
                            state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ack takes priority, so an ack on the last allowed cycle still succeeds.
                    if (mem_ack) begin
                        err_q <= 2'd0;
                        state <= S_RESP;
                        if (!wr_q) begin
                            rdata_q   <= ld_ext;
                            resp_rd_q <= rd_q;
                        end
                    end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                        err_q <= 2'd2;
                        state <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bus strobes decode straight from state so reset drops them without waiting for a clock.
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_rd    = resp_rd_q;
    assign resp_err   = err_q;
    assign mem_rd     = (state == S_BUS) && !wr_q;
    assign mem_wr     = (state == S_BUS) && wr_q;
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign mem_wdata  = wdata_q << {off, 3'b000};
    assign mem_wstrb  = mem_wr ? (size_mask << off) : '0;

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Bench for the load/store unit: a 32-bit instance (default timeout) and a 64-bit instance (TIMEOUT=4).
// One stimulus process drives whichever instance is selected; a monitor scores responses from a queue.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_ysyx_23060180_lsu;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel;
    logic        req_valid, req_wr, resp_ready, mem_ack;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic [63:0] mem_rdata;

    // 32-bit instance signals
    logic        a_req_ready, a_resp_valid, a_mem_rd, a_mem_wr;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [4:0]  a_resp_rd;
    logic [1:0]  a_resp_err;
    logic [3:0]  a_mem_wstrb;
    // 64-bit instance signals
    logic        b_req_ready, b_resp_valid, b_mem_rd, b_mem_wr;
    logic [63:0] b_resp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [4:0]  b_resp_rd;
    logic [1:0]  b_resp_err;
    logic [7:0]  b_mem_wstrb;

    // Observed view of the selected instance
    logic        o_req_ready, o_resp_valid, o_mem_rd, o_mem_wr;
    logic [63:0] o_resp_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr;
    logic [4:0]  o_resp_rd;
    logic [1:0]  o_resp_err;
    logic [7:0]  o_mem_wstrb;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ysyx_23060180_lsu #(.XLEN(32), .ADDR_W(32)) u_a (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_wr(req_wr),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel), .resp_rdata(a_resp_rdata),
        .resp_rd(a_resp_rd), .resp_err(a_resp_err),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_wstrb(a_mem_wstrb), .mem_rdata(mem_rdata[31:0]), .mem_ack(mem_ack && !sel)
    );

    ysyx_23060180_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4), .CNT_W(3)) u_b (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_wr(req_wr),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel), .resp_rdata(b_resp_rdata),
        .resp_rd(b_resp_rd), .resp_err(b_resp_err),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack && sel)
    );

    assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign o_mem_rd     = sel ? b_mem_rd     : a_mem_rd;
    assign o_mem_wr     = sel ? b_mem_wr     : a_mem_wr;
    assign o_resp_rdata = sel ? b_resp_rdata : {32'b0, a_resp_rdata};
    assign o_mem_wdata  = sel ? b_mem_wdata  : {32'b0, a_mem_wdata};
    assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
    assign o_resp_rd    = sel ? b_resp_rd    : a_resp_rd;
    assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
    assign o_mem_wstrb  = sel ? b_mem_wstrb  : {4'b0, a_mem_wstrb};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Response monitor: every accepted response is scored against the oldest expectation.
    always @(negedge clk) begin
        if (rstn && o_resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got err %0d with no response expected", o_resp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_err",   64'(o_resp_err), 64'(e.err));
                chk("resp_rdata", o_resp_rdata,    e.data);
                chk("resp_rd",    64'(o_resp_rd),  64'(e.rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and play the bus: ack in bus cycle ack_at (-1 = never), expect exp_cyc bus cycles.
    task automatic op(input bit s, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] mrd,
                      input int ack_at, input int exp_cyc, input logic [1:0] e_err,
                      input logic [63:0] e_data, input logic [4:0] e_rd, input logic [7:0] e_strb,
                      input logic [63:0] e_wdata, input logic [31:0] e_maddr, input int hold);
        exp_t e;
        int   n;
        sel = s;
        req_valid = 1'b1; req_wr = wr; req_func3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
        #1;
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        e.data = e_data; e.rd = e_rd; e.err = e_err;
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
        n = 0;
        while ((o_mem_rd || o_mem_wr) && n < 50) begin
            chk("mem_rd",    64'(o_mem_rd),    64'(!wr));
            chk("mem_wr",    64'(o_mem_wr),    64'(wr));
            chk("mem_addr",  64'(o_mem_addr),  64'(e_maddr));
            chk("mem_wstrb", 64'(o_mem_wstrb), 64'(e_strb));
            if (wr) chk("mem_wdata", o_mem_wdata, e_wdata);
            if (n == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = mrd;
            end
            tick();
            mem_ack = 1'b0;
            mem_rdata = '0;
            n++;
        end
        chk("bus_cycles", 64'(n), 64'(exp_cyc));
        chk("resp_valid_latency", 64'(o_resp_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            chk("hold_req_ready",  64'(o_req_ready),  64'd0);
            chk("hold_resp_valid", 64'(o_resp_valid), 64'd1);
            chk("hold_rdata",      o_resp_rdata,      e_data);
            chk("hold_err",        64'(o_resp_err),   64'(e_err));
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("post_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("post_req_ready",  64'(o_req_ready),  64'd1);
    endtask

    initial begin
        rstn = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_func3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_req_ready",  64'(o_req_ready),  64'd1);
        chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst_resp_err",   64'(o_resp_err),   64'd0);
        chk("rst_resp_rdata", o_resp_rdata,      64'd0);
        chk("rst_resp_rd",    64'(o_resp_rd),    64'd0);
        chk("rst_mem_rd",     64'(o_mem_rd),     64'd0);
        chk("rst_mem_wr",     64'(o_mem_wr),     64'd0);
        chk("rst_mem_wstrb",  64'(o_mem_wstrb),  64'd0);
        tick();
        rstn = 1'b1;
        tick();

        //  s  wr f3      addr           wdata                  rd mem_rdata               ack cyc err exp_data                rd strb   exp_wdata               maddr          hold
        op(0, 0, 3'b000, 32'h80000003, 64'h0,                  5, 64'h80FF1234,          0,  1,  0, 64'hFFFFFF80,           5, 8'h00, 64'h0,                  32'h80000000, 0);
        op(0, 1, 3'b001, 32'h80000002, 64'h0000ABCD,           7, 64'h0,                 4,  5,  0, 64'h0,                  0, 8'h0C, 64'hABCD0000,           32'h80000000, 0);
        op(0, 0, 3'b010, 32'h80000001, 64'h0,                  3, 64'h0,                -1,  0,  1, 64'h0,                  0, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 0, 3'b010, 32'h80000004, 64'h0,                 10, 64'hDEADBEEF,          0,  1,  0, 64'hDEADBEEF,          10, 8'h00, 64'h0,                  32'h80000004, 3);
        op(0, 0, 3'b011, 32'h80000000, 64'h0,                  4, 64'h0,                -1,  0,  3, 64'h0,                  0, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 0, 3'b101, 32'h00000002, 64'h0,                  6, 64'h80010000,          0,  1,  0, 64'h00008001,           6, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 0, 3'b001, 32'h00000002, 64'h0,                  6, 64'h80010000,          1,  2,  0, 64'hFFFF8001,           6, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 1, 3'b000, 32'h00000001, 64'h12345678,           9, 64'h0,                 0,  1,  0, 64'h0,                  0, 8'h02, 64'h34567800,           32'h0,        0);
        op(0, 1, 3'b100, 32'h00000000, 64'h0,                  9, 64'h0,                -1,  0,  3, 64'h0,                  0, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 1, 3'b010, 32'h00000002, 64'h0,                  9, 64'h0,                -1,  0,  1, 64'h0,                  0, 8'h00, 64'h0,                  32'h0,        0);
        op(0, 0, 3'b100, 32'h00000000, 64'h0,                  1, 64'h000000F0,          0,  1,  0, 64'h000000F0,           1, 8'h00, 64'h0,                  32'h0,        0);
        op(1, 0, 3'b011, 32'h00000008, 64'h0,                  2, 64'h8123456789ABCDEF,  0,  1,  0, 64'h8123456789ABCDEF,   2, 8'h00, 64'h0,                  32'h8,        0);
        op(1, 0, 3'b010, 32'h00000010, 64'h0,                  3, 64'h0,                -1,  4,  2, 64'h0,                  0, 8'h00, 64'h0,                  32'h10,       0);
        op(1, 0, 3'b010, 32'h00000014, 64'h0,                  3, 64'hCAFEBABE00000000,  3,  4,  0, 64'hFFFFFFFFCAFEBABE,   3, 8'h00, 64'h0,                  32'h10,       0);
        op(1, 1, 3'b011, 32'h00000008, 64'h1122334455667788,   4, 64'h0,                 0,  1,  0, 64'h0,                  0, 8'hFF, 64'h1122334455667788,   32'h8,        0);
        op(1, 0, 3'b110, 32'h00000004, 64'h0,                  8, 64'h89ABCDEF00000000,  0,  1,  0, 64'h0000000089ABCDEF,   8, 8'h00, 64'h0,                  32'h0,        0);
        op(1, 1, 3'b010, 32'h00000004, 64'hAABBCCDD,           8, 64'h0,                 0,  1,  0, 64'h0,                  0, 8'hF0, 64'hAABBCCDD00000000,   32'h0,        0);
        op(1, 0, 3'b011, 32'h00000004, 64'h0,                  8, 64'h0,                -1,  0,  1, 64'h0,                  0, 8'h00, 64'h0,                  32'h0,        0);

        // Reset while the 32-bit unit is waiting on the bus: no response may follow.
        sel = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_func3 = 3'b010; req_addr = 32'h80000008; req_rd = 5'd12;
        tick();
        req_valid = 1'b0;
        chk("rstmid_mem_rd_before", 64'(o_mem_rd), 64'd1);
        tick();
        rstn = 1'b0;
        #1;
        chk("rstmid_mem_rd_drop", 64'(o_mem_rd),     64'd0);
        chk("rstmid_resp_valid",  64'(o_resp_valid), 64'd0);
        chk("rstmid_req_ready",   64'(o_req_ready),  64'd1);
        tick();
        rstn = 1'b1;
        resp_ready = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 64'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid_late_ack_resp", 64'(o_resp_valid), 64'd0);
            chk("rstmid_late_ack_rd",   64'(o_mem_rd),     64'd0);
        end
        mem_ack = 1'b0;
        resp_ready = 1'b0;
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
